// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared timer/clock types: state enum, BCD digit type and limits
package clock_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_RING  = 2'd3
  } state_e;

  localparam bcd_t BCD_MAX_UNITS = 4'd9;
  localparam bcd_t BCD_MAX_TENS  = 4'd5;

  function automatic bcd_t clamp_bcd(input bcd_t v, input bcd_t max_v);
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// rtl/bcd_down_digit.sv - one BCD down-counting digit; wraps 0 -> WRAP and flags bout at zero
module bcd_down_digit
  import clock_pkg::*;
#(
  parameter bcd_t WRAP = BCD_MAX_UNITS
) (
  input  logic CP,
  input  logic nCR,
  input  logic load,
  input  bcd_t ld_val,
  input  logic dec,
  output bcd_t q,
  output logic bout
);

  bcd_t q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = ld_val;
    end else if (dec) begin
      q_d = (q_q == 4'd0) ? WRAP : (q_q - 4'd1);
    end
  end

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q    = q_q;
  assign bout = (q_q == 4'd0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - MM:SS BCD countdown timer with done pulse and ring phase
// Optional: COUNTDOWN_BLINK_EN adds a blink phase flop toggled by tick in PAUSE/RING.
module bcd_countdown_timer
  import clock_pkg::*;
#(
  parameter int RING_TICKS = 10,
  parameter int TICK_W     = 8
) (
  input  logic       CP,
  input  logic       nCR,
  input  logic       tick,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic [3:0] lmh,
  input  logic [3:0] lml,
  input  logic [3:0] lsh,
  input  logic [3:0] lsl,
  output logic [3:0] qmh,
  output logic [3:0] qml,
  output logic [3:0] qsh,
  output logic [3:0] qsl,
  output logic       running,
  output logic       done,
  output logic       alarm,
  output logic       blink
);

  state_e              state_q, state_d;
  logic [TICK_W-1:0]   ring_cnt_q, ring_cnt_d;
  logic                done_q, done_d;
  logic                ld_acc, dec_en;
  logic                mh_bout, ml_bout, sh_bout, sl_bout;
  logic                count_zero, count_one;

  assign count_zero = mh_bout & ml_bout & sh_bout & sl_bout;
  assign count_one  = mh_bout & ml_bout & sh_bout & (qsl == 4'd1);

  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    done_d     = 1'b0;
    ld_acc     = 1'b0;
    dec_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          ld_acc = 1'b1;
        end else if (start && !count_zero) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // pause beats start here; load is ignored while running
        if (pause) begin
          state_d = ST_PAUSE;
        end else if (tick && !count_zero) begin
          dec_en = 1'b1;
          if (count_one) begin
            state_d    = ST_RING;
            done_d     = 1'b1;
            ring_cnt_d = '0;
          end
        end
      end
      ST_PAUSE: begin
        if (load) begin
          ld_acc  = 1'b1;
          state_d = ST_IDLE;
        end else if (start && !count_zero) begin
          state_d = ST_RUN;
        end
      end
      ST_RING: begin
        if (load) begin
          ld_acc  = 1'b1;
          state_d = ST_IDLE;
        end else if (start) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (ring_cnt_q == TICK_W'(RING_TICKS - 1)) begin
            state_d    = ST_IDLE;
            ring_cnt_d = '0;
          end else begin
            ring_cnt_d = ring_cnt_q + TICK_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      state_q    <= ST_IDLE;
      ring_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      done_q     <= done_d;
    end
  end

  bcd_down_digit #(.WRAP(BCD_MAX_UNITS)) u_sl (
    .CP(CP), .nCR(nCR), .load(ld_acc), .ld_val(clamp_bcd(lsl, BCD_MAX_UNITS)),
    .dec(dec_en), .q(qsl), .bout(sl_bout)
  );
  bcd_down_digit #(.WRAP(BCD_MAX_TENS)) u_sh (
    .CP(CP), .nCR(nCR), .load(ld_acc), .ld_val(clamp_bcd(lsh, BCD_MAX_TENS)),
    .dec(dec_en & sl_bout), .q(qsh), .bout(sh_bout)
  );
  bcd_down_digit #(.WRAP(BCD_MAX_UNITS)) u_ml (
    .CP(CP), .nCR(nCR), .load(ld_acc), .ld_val(clamp_bcd(lml, BCD_MAX_UNITS)),
    .dec(dec_en & sl_bout & sh_bout), .q(qml), .bout(ml_bout)
  );
  bcd_down_digit #(.WRAP(BCD_MAX_TENS)) u_mh (
    .CP(CP), .nCR(nCR), .load(ld_acc), .ld_val(clamp_bcd(lmh, BCD_MAX_TENS)),
    .dec(dec_en & sl_bout & sh_bout & ml_bout), .q(qmh), .bout(mh_bout)
  );

`ifdef COUNTDOWN_BLINK_EN
  logic blink_q, blink_d;

  // phase restarts at 0 whenever PAUSE/RING is (re)entered
  always_comb begin
    blink_d = 1'b0;
    if ((state_d == ST_PAUSE || state_d == ST_RING) && state_d == state_q) begin
      blink_d = blink_q ^ tick;
    end
  end

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      blink_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
    end
  end

  assign blink = blink_q;
`else
  assign blink = 1'b0;
`endif

  assign running = (state_q == ST_RUN);
  assign alarm   = (state_q == ST_RING);
  assign done    = done_q;

endmodule
